// File: rtl/fft_pkg.sv
// Shared FFT datapath defaults and the complex-pair type.
package fft_pkg;
  localparam int DATA_WIDTH_DEF = 64;
  localparam int TW_FRAC_DEF = 0;

  typedef struct packed {
    logic signed [DATA_WIDTH_DEF-1:0] r;
    logic signed [DATA_WIDTH_DEF-1:0] i;
  } cpx_t;
endpackage

// File: rtl/cmult_conj.sv
// Registered d*conj(w): S2 holds the four products, S3 the combined outputs.
// IFFT_BUTTERFLY_SCALE_EN halves every output in S3 (floor).
module cmult_conj
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TW_FRAC = TW_FRAC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  logic [DATA_WIDTH-1:0] d_r,
  input  logic [DATA_WIDTH-1:0] d_i,
  input  logic [DATA_WIDTH-1:0] w_r,
  input  logic [DATA_WIDTH-1:0] w_i,
  input  logic [DATA_WIDTH-1:0] a_r,
  input  logic [DATA_WIDTH-1:0] a_i,
  output logic out_valid,
  input  logic out_ready,
  output logic [DATA_WIDTH-1:0] y1_r,
  output logic [DATA_WIDTH-1:0] y1_i,
  output logic [DATA_WIDTH-1:0] y2_r,
  output logic [DATA_WIDTH-1:0] y2_i
);
  localparam int W2 = 2 * DATA_WIDTH;
`ifdef IFFT_BUTTERFLY_SCALE_EN
  localparam int SH = 1;
`else
  localparam int SH = 0;
`endif

  logic v2, v3, ld2, ld3;
  logic signed [W2-1:0] p_rr, p_ii, p_ir, p_ri;
  logic [DATA_WIDTH-1:0] a2_r, a2_i;
  logic signed [W2:0] re_f, im_f;
  logic signed [DATA_WIDTH-1:0] re_t, im_t;
  logic signed [DATA_WIDTH-1:0] s_r, s_i;

  assign ld3 = !v3 || out_ready;
  assign ld2 = !v2 || ld3;
  assign in_ready = ld2;
  assign out_valid = v3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2   <= 1'b0;
      p_rr <= '0;
      p_ii <= '0;
      p_ir <= '0;
      p_ri <= '0;
      a2_r <= '0;
      a2_i <= '0;
    end else if (ld2) begin
      v2 <= in_valid;
      if (in_valid) begin
        p_rr <= W2'($signed(d_r)) * W2'($signed(w_r));
        p_ii <= W2'($signed(d_i)) * W2'($signed(w_i));
        p_ir <= W2'($signed(d_i)) * W2'($signed(w_r));
        p_ri <= W2'($signed(d_r)) * W2'($signed(w_i));
        a2_r <= a_r;
        a2_i <= a_i;
      end
    end
  end

  // one guard bit so the pre-shift sum never overflows
  always_comb begin
    re_f = (W2+1)'(p_rr) + (W2+1)'(p_ii);
    im_f = (W2+1)'(p_ir) - (W2+1)'(p_ri);
    re_t = DATA_WIDTH'(re_f >>> TW_FRAC);
    im_t = DATA_WIDTH'(im_f >>> TW_FRAC);
    s_r  = a2_r;
    s_i  = a2_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3   <= 1'b0;
      y1_r <= '0;
      y1_i <= '0;
      y2_r <= '0;
      y2_i <= '0;
    end else if (ld3) begin
      v3 <= v2;
      if (v2) begin
        y1_r <= s_r >>> SH;
        y1_i <= s_i >>> SH;
        y2_r <= re_t >>> SH;
        y2_i <= im_t >>> SH;
      end
    end
  end
endmodule

// File: rtl/ifft_butterfly_pipe.sv
// Pipelined DIF inverse butterfly: y1 = x1+x2, y2 = (x1-x2)*conj(w).
// Optional IFFT_BUTTERFLY_SCALE_EN halves outputs; latency is 3 either way.
module ifft_butterfly_pipe
  import fft_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int TW_FRAC = TW_FRAC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic [DATA_WIDTH-1:0] x1_r,
  input  logic [DATA_WIDTH-1:0] x1_i,
  input  logic [DATA_WIDTH-1:0] x2_r,
  input  logic [DATA_WIDTH-1:0] x2_i,
  input  logic [DATA_WIDTH-1:0] twiddle_r,
  input  logic [DATA_WIDTH-1:0] twiddle_i,
  input  logic in_valid,
  output logic in_ready,
  output logic [DATA_WIDTH-1:0] y1_r,
  output logic [DATA_WIDTH-1:0] y1_i,
  output logic [DATA_WIDTH-1:0] y2_r,
  output logic [DATA_WIDTH-1:0] y2_i,
  output logic out_valid,
  input  logic out_ready
);
  logic ready_en, v1, ld1, cm_ready;
  logic [DATA_WIDTH-1:0] s_r, s_i, d_r, d_i, w_r, w_i;

  // holds in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  assign ld1 = ready_en && (!v1 || cm_ready);
  assign in_ready = ld1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      s_r <= '0;
      s_i <= '0;
      d_r <= '0;
      d_i <= '0;
      w_r <= '0;
      w_i <= '0;
    end else if (ld1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s_r <= x1_r + x2_r;
        s_i <= x1_i + x2_i;
        d_r <= x1_r - x2_r;
        d_i <= x1_i - x2_i;
        w_r <= twiddle_r;
        w_i <= twiddle_i;
      end
    end
  end

  cmult_conj #(
    .DATA_WIDTH(DATA_WIDTH),
    .TW_FRAC(TW_FRAC)
  ) u_cm (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(v1),
    .in_ready(cm_ready),
    .d_r(d_r),
    .d_i(d_i),
    .w_r(w_r),
    .w_i(w_i),
    .a_r(s_r),
    .a_i(s_i),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .y1_r(y1_r),
    .y1_i(y1_i),
    .y2_r(y2_r),
    .y2_i(y2_i)
  );
endmodule

// File: tb/tb_ifft_butterfly_pipe.sv
// Directed bench for ifft_butterfly_pipe (default params).
// Expected values follow IFFT_BUTTERFLY_SCALE_EN when it is defined.
module tb_ifft_butterfly_pipe;
  import fft_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [63:0] x1_r, x1_i, x2_r, x2_i, twiddle_r, twiddle_i;
  logic [63:0] y1_r, y1_i, y2_r, y2_i;
  logic in_valid, in_ready, out_valid, out_ready;
  int errs = 0;
  int checks = 0;
  int acc, got, seen, k;

  always #5 clk = ~clk;

  ifft_butterfly_pipe dut (
    .clk(clk),
    .rst_n(rst_n),
    .x1_r(x1_r),
    .x1_i(x1_i),
    .x2_r(x2_r),
    .x2_i(x2_i),
    .twiddle_r(twiddle_r),
    .twiddle_i(twiddle_i),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .y1_r(y1_r),
    .y1_i(y1_i),
    .y2_r(y2_r),
    .y2_i(y2_i),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  task automatic chk(input string tag, input logic [63:0] got_v,
                     input logic [63:0] exp_v);
    checks++;
    if (got_v !== exp_v) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got_v, exp_v);
    end
  endtask

  function automatic cpx_t cx(input longint r, input longint i);
    return {r, i};
  endfunction

  function automatic logic [63:0] sc(input logic [63:0] v);
`ifdef IFFT_BUTTERFLY_SCALE_EN
    return $signed(v) >>> 1;
`else
    return v;
`endif
  endfunction

  task automatic put(input cpx_t a, input cpx_t b, input cpx_t w);
    x1_r = a.r;
    x1_i = a.i;
    x2_r = b.r;
    x2_i = b.i;
    twiddle_r = w.r;
    twiddle_i = w.i;
    in_valid = 1'b1;
  endtask

  task automatic chk_y(input string tag, input cpx_t e1, input cpx_t e2);
    chk({tag, ".y1r"}, y1_r, sc(e1.r));
    chk({tag, ".y1i"}, y1_i, sc(e1.i));
    chk({tag, ".y2r"}, y2_r, sc(e2.r));
    chk({tag, ".y2i"}, y2_i, sc(e2.i));
  endtask

  task automatic one(input string tag, input cpx_t a, input cpx_t b,
                     input cpx_t w, input cpx_t e1, input cpx_t e2);
    @(negedge clk);
    put(a, b, w);
    out_ready = 1'b1;
    chk({tag, ".rdy"}, 64'(in_ready), 64'(1));
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk({tag, ".early"}, 64'(out_valid), 64'(0));
    @(negedge clk);
    chk({tag, ".ov"}, 64'(out_valid), 64'(1));
    chk_y(tag, e1, e2);
  endtask

  function automatic cpx_t bp_a(input int i);
    return cx(longint'(1000 + i), longint'(i));
  endfunction
  function automatic cpx_t bp_b(input int i);
    return cx(longint'(2 * i), 64'sd7);
  endfunction

  initial begin
    in_valid = 1'b0;
    out_ready = 1'b0;
    x1_r = '0; x1_i = '0; x2_r = '0; x2_i = '0;
    twiddle_r = '0; twiddle_i = '0;

    #12;
    chk("rst.ov", 64'(out_valid), 64'(0));
    chk("rst.ir", 64'(in_ready), 64'(0));
    chk("rst.y1r", y1_r, 64'(0));
    chk("rst.y2i", y2_i, 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("rel.ir", 64'(in_ready), 64'(1));

    one("base", cx(10, 33), cx(45, -24), cx(1, 0), cx(55, 9), cx(-35, 57));
    one("rot", cx(10, 33), cx(45, -24), cx(0, 1), cx(55, 9), cx(57, 35));
    one("wrap", cx(64'sh7FFF_FFFF_FFFF_FFFF, 0), cx(1, 0), cx(1, 0),
        cx(64'sh8000_0000_0000_0000, 0), cx(64'sh7FFF_FFFF_FFFF_FFFE, 0));

    // back-to-back: input c shows up at negedge c+3
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk($sformatf("tp.ov%0d", c), 64'(out_valid), 64'(c >= 3 && c < 11));
      if (c >= 3 && c < 11) begin
        k = c - 3;
        chk_y($sformatf("tp%0d", k),
              cx(longint'(100 + 8 * k), longint'(50 - 4 * k)),
              cx(longint'(100 + 6 * k), longint'(-50 - 2 * k)));
      end
      if (c < 8) begin
        put(cx(longint'(100 + 7 * c), longint'(-3 * c)),
            cx(longint'(c), longint'(50 - c)), cx(1, 0));
        chk($sformatf("tp.rdy%0d", c), 64'(in_ready), 64'(1));
      end else begin
        in_valid = 1'b0;
      end
    end

    // back-pressure: three accepts fill the pipe, output held
    out_ready = 1'b0;
    acc = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      put(bp_a(acc), bp_b(acc), cx(0, 1));
      chk($sformatf("bp.rdy%0d", c), 64'(in_ready), 64'(c < 3));
      if (c >= 3) begin
        chk($sformatf("bp.ov%0d", c), 64'(out_valid), 64'(1));
        chk($sformatf("bp.hold%0d", c), y1_r, sc(64'(1000)));
        chk($sformatf("bp.hold2i%0d", c), y2_i, sc(64'(-1000)));
      end
      if (in_ready) acc++;
    end
    chk("bp.acc", 64'(acc), 64'(3));
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    got = 0;
    for (int t = 0; t < 20 && got < 3; t++) begin
      if (out_valid) begin
        chk_y($sformatf("bp%0d", got),
              cx(longint'(1000 + 3 * got), longint'(got + 7)),
              cx(longint'(got - 7), longint'(got - 1000)));
        got++;
      end
      @(negedge clk);
    end
    chk("bp.cnt", 64'(got), 64'(3));

    // reset with two transfers in flight (S3 and S2)
    @(negedge clk);
    out_ready = 1'b0;
    put(cx(10, 33), cx(45, -24), cx(1, 0));
    @(negedge clk);
    put(cx(10, 33), cx(45, -24), cx(0, 1));
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    chk("mid.ov_pre", 64'(out_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    chk("mid.ov", 64'(out_valid), 64'(0));
    chk("mid.ir", 64'(in_ready), 64'(0));
    chk("mid.y1r", y1_r, 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("mid.stale", 64'(seen), 64'(0));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
